// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and default latencies, also used by the instruction decoder.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Multi-cycle ops occupy codes 0..3, so bit 2 clear identifies them.
  function automatic logic is_muldiv(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/md_result.sv
// Combinational HI/LO result for a latched mult/div; wr_en drops for
// divide-by-zero and for any op that does not produce a result.
module md_result
  import muldiv_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        wr_en
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] quot_u;
  logic [31:0] rem_u;
  logic [31:0] quot;
  logic [31:0] rem;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes; 0x80000000 / -1 then wraps naturally.
  assign signed_div = (op == MD_DIV);
  assign neg_a      = signed_div & a[31];
  assign neg_b      = signed_div & b[31];
  assign mag_a      = neg_a ? (~a + 32'd1) : a;
  assign mag_b      = neg_b ? (~b + 32'd1) : b;
  assign divisor    = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign quot_u     = mag_a / divisor;
  assign rem_u      = mag_a % divisor;
  assign quot       = (neg_a ^ neg_b) ? (~quot_u + 32'd1) : quot_u;
  assign rem        = neg_a ? (~rem_u + 32'd1) : rem_u;

  always_comb begin
    result = 64'd0;
    wr_en  = 1'b0;
    case (op)
      MD_MULT: begin
        result = prod_s;
        wr_en  = 1'b1;
      end
      MD_MULTU: begin
        result = prod_u;
        wr_en  = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        result = {rem, quot};
        wr_en  = (b != 32'd0);
      end
      default: begin
        result = 64'd0;
        wr_en  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: fixed-latency busy window, HI/LO
// registers and the pipeline stall request for instructions touching them.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MULT_N = (MULT_CYCLES < 1) ? 1 : MULT_CYCLES;
  localparam int DIV_N  = (DIV_CYCLES < 1) ? 1 : DIV_CYCLES;
  localparam int MAX_N  = (MULT_N > DIV_N) ? MULT_N : DIV_N;
  localparam int CNT_W  = $clog2(MAX_N + 1);

  md_state_e   state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  md_op_e      op_reg, op_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [63:0] result;
  logic        result_wr;

  md_result u_result (
    .op     (op_reg),
    .a      (a_reg),
    .b      (b_reg),
    .result (result),
    .wr_en  (result_wr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      op_reg    <= MD_MULT;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          case (md_op_e'(op))
            MD_MULT, MD_MULTU: begin
              op_next    = md_op_e'(op);
              a_next     = a;
              b_next     = b;
              count_next = CNT_W'(MULT_N);
              state_next = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              op_next    = md_op_e'(op);
              a_next     = a;
              b_next     = b;
              count_next = CNT_W'(DIV_N);
              state_next = ST_RUN;
            end
            MD_MTHI: hi_next = a;
            MD_MTLO: lo_next = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Completion edge: results land as busy drops.
        if (count_reg <= CNT_W'(1)) begin
          state_next = ST_IDLE;
          count_next = '0;
          if (result_wr) begin
            hi_next = result[63:32];
            lo_next = result[31:0];
          end
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy      = (state_reg == ST_RUN);
  assign stall_req = ~reset & md_use & (busy | (start & is_muldiv(op)));
  assign hi        = hi_reg;
  assign lo        = lo_reg;

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, is the busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, is the busy cycles for div/divu.
REQ-003 Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit, is the reset: synchronous and active-high.
REQ-005 Port start, input, 1 bit, is the E-stage md instruction valid strobe.
REQ-006 Port op, input, 3 bits, is the operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO; other codes are no-op.
REQ-007 Port a, input, 32 bits, is the rs operand.
REQ-008 Port b, input, 32 bits, is the rt operand.
REQ-009 Port md_use, input, 1 bit, flags a D-stage instruction that touches HI/LO (mult*/div*/mfhi/mflo/mthi/mtlo).
REQ-010 Port busy, output, 1 bit, is high while a mult/div is in flight.
REQ-011 Port stall_req, output, 1 bit, is the pipeline freeze request to the hazard unit.
REQ-012 Port hi, output, 32 bits, is the architectural HI register.
REQ-013 Port lo, output, 32 bits, is the architectural LO register.

Function
REQ-014 start SHALL be accepted only when busy=0; start with busy=1 is ignored, and the pipeline never issues it because stall_req is high.
REQ-015 Accepted MULT/MULTU/DIV/DIVU SHALL latch operands and op, load the counter with N = MULT_CYCLES or DIV_CYCLES, and enter state RUN.
REQ-016 States: IDLE (busy=0) and RUN (busy=1); IDLE->RUN on accepted mult/div; RUN->IDLE when the counter reaches 1 at a clock edge.
REQ-017 Start sampled at edge t: busy SHALL be high for cycles t+1..t+N; HI/LO SHALL update at edge t+N, with busy low in the same cycle the new values are visible.
REQ-018 Counter SHALL decrement by 1 per cycle in RUN; no wrap-around; it never loads below 1.
REQ-019 MTHI/MTLO accepted SHALL write a into hi/lo at the next edge, with no busy cycles.
REQ-020 MULT SHALL produce the signed 64-bit product, MULTU the unsigned one; {hi,lo} = product.
REQ-021 DIV SHALL produce a signed quotient truncated toward zero into lo and a remainder with the dividend's sign into hi; DIVU SHALL be the unsigned equivalent.
REQ-022 Division by zero (b=0) SHALL run the full DIV_CYCLES with hi/lo left unchanged.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-024 stall_req SHALL equal md_use & (busy | (start & op is mult/div)), and is combinational.
REQ-025 hi/lo SHALL be stable during RUN; mfhi/mflo reads are blocked by stall_req.
REQ-026 Operand changes on a/b during RUN SHALL NOT affect the result.

Reset
REQ-027 With reset=1 at an edge: state IDLE, counter 0, busy=0, hi=0, lo=0; an in-flight operation is discarded with no HI/LO write.
REQ-028 reset SHALL take priority over start in the same cycle.
REQ-029 stall_req SHALL be 0 during reset regardless of md_use.

Structure
REQ-030 The package muldiv_pkg SHALL hold the op encodings (MD_MULT=0 ... MD_MTLO=5), state encodings, and the default cycle constants, shared with the decoder.
REQ-031 A combinational sub-module md_result SHALL compute the 64-bit {hi,lo} result from the latched op, a and b; muldiv_ctrl owns the FSM, counter and registers.

Verification
REQ-032 MULT a=0xFFFFFFFE, b=3 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 MULTU a=0xFFFFFFFF, b=2 -> hi=1, lo=0xFFFFFFFE after 5 cycles.
REQ-034 DIV a=-7, b=2 -> busy 10 cycles, then lo=-3 (0xFFFFFFFD), hi=-1; md_use=1 during busy -> stall_req=1 every cycle.
REQ-035 DIVU a=5, b=0 -> 10 busy cycles, hi/lo unchanged; then MTLO a=0x1234 -> lo=0x1234 next cycle, busy=0.
REQ-036 DIV started, reset asserted at busy cycle 4 -> next cycle busy=0, hi=lo=0, no later write.
REQ-037 start with a MULT while busy=1 -> ignored; the first result lands at cycle t+N exactly.
